// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction-fetch (I) and data (D) ports.
// One transaction is outstanding at a time, and a watchdog aborts it if memory never responds.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_owner_d;     // owner of the current/last grant; doubles as last_owner
    logic [CNT_W-1:0]    r_cnt;
    logic                r_m_we;
    logic [BE_W-1:0]     r_m_be;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;

    logic                w_grant;
    logic                w_win_d;
    logic                w_done;
    logic                w_abort;
    logic                w_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_win_d      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant      = 1'b1;
                    // On contention the port that did not win last time goes first.
                    w_win_d      = d_req && (!i_req || !r_owner_d);
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (m_gnt && m_rvalid) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == TIMEOUT_VAL) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (m_gnt) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == TIMEOUT_VAL) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_d <= 1'b0;
            r_cnt     <= '0;
            r_m_we    <= 1'b0;
            r_m_be    <= '0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else if (w_grant) begin
            r_owner_d <= w_win_d;
            r_cnt     <= CNT_W'(1);
            if (w_win_d) begin
                r_m_we    <= d_we;
                r_m_be    <= d_be;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
            end else begin
                r_m_we    <= 1'b0;
                r_m_be    <= '1;
                r_m_addr  <= i_addr;
                r_m_wdata <= '0;
            end
        end else if (w_state_next != IDLE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Grants are combinational from the request inputs, so mask them while reset is held.
    assign i_gnt    = rst_n & w_grant & ~w_win_d;
    assign d_gnt    = rst_n & w_grant &  w_win_d;

    assign w_resp   = w_done | w_abort;
    assign i_rvalid = w_resp  & ~r_owner_d;
    assign i_err    = w_abort & ~r_owner_d;
    assign i_rdata  = (w_done & ~r_owner_d) ? m_rdata : '0;
    assign d_rvalid = w_resp  &  r_owner_d;
    assign d_err    = w_abort &  r_owner_d;
    assign d_rdata  = (w_done &  r_owner_d) ? m_rdata : '0;

    assign m_req    = (r_state == REQ);
    assign m_we     = r_m_we;
    assign m_be     = r_m_be;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: arbitration table, directed corner cases,
// and random transactions checked against a transaction-level model of the port.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_gnt, i_rvalid, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we, m_gnt, m_rvalid, busy;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_mreq"},   m_req, 0);
        chk({tag, "_mwe"},    m_we, 0);
        chk({tag, "_mbe"},    m_be, 0);
        chk({tag, "_maddr"},  m_addr, 0);
        chk({tag, "_mwdata"}, m_wdata, 0);
        chk({tag, "_gnt"},    {i_gnt, d_gnt}, 0);
        chk({tag, "_rvalid"}, {i_rvalid, d_rvalid}, 0);
        chk({tag, "_err"},    {i_err, d_err}, 0);
        chk({tag, "_rdata"},  {i_rdata, d_rdata}, 0);
    endtask

    // Reference model: last winner, plus each port's pending (held) request.
    bit            m_last_d;
    bit            p_i, p_d;
    logic [AW-1:0] p_ia, p_da;
    logic          p_dwe;
    logic [BW-1:0] p_dbe;
    logic [DW-1:0] p_dwd;
    bit            obs_gnt_d;

    task automatic drive_reqs();
        i_req   = p_i;
        i_addr  = p_ia;
        d_req   = p_d;
        d_we    = p_dwe;
        d_be    = p_dbe;
        d_addr  = p_da;
        d_wdata = p_dwd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_last_d = 1'b0;
        p_i      = 1'b0;
        p_d      = 1'b0;
    endtask

    // One transaction from its IDLE grant cycle. Memory grants in cycle g after m_req
    // rises (cycle 1) and responds r cycles later; past TO cycles the port must abort.
    task automatic run_txn(input int g, input int r, input logic [DW-1:0] rd);
        bit            wd, ab, last;
        int            c, end_k;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [BW-1:0] ebe;
        logic [DW-1:0] ewd, erd;
        drive_reqs();
        m_gnt    = 1'b0;
        m_rvalid = 1'($urandom);
        m_rdata  = $urandom;
        wd = p_d && (!p_i || !m_last_d);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_mreq", m_req, 0);
        chk("gnt_i", i_gnt, !wd);
        chk("gnt_d", d_gnt, wd);
        chk("idle_rvalid", {i_rvalid, d_rvalid}, 0);
        obs_gnt_d = d_gnt;
        m_last_d  = wd;
        if (wd) begin
            ea = p_da; ewe = p_dwe; ebe = p_dbe; ewd = p_dwd; p_d = 1'b0;
        end else begin
            ea = p_ia; ewe = 1'b0; ebe = '1; ewd = '0; p_i = 1'b0;
        end
        c     = g + r;
        ab    = (c > TO);
        end_k = ab ? TO : c;
        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk);
            #1;
            drive_reqs();
            m_gnt    = (k == g) ? 1'b1 : ((k > g) ? 1'($urandom) : 1'b0);
            m_rvalid = (k == c) ? 1'b1 : ((k < g) ? 1'($urandom) : 1'b0);
            m_rdata  = (k == c) ? rd : $urandom;
            @(negedge clk);
            chk("busy", busy, 1);
            chk("gnt_while_busy", {i_gnt, d_gnt}, 0);
            chk("m_req", m_req, (k <= g));
            if (k <= g) begin
                chk("m_addr", m_addr, ea);
                chk("m_we", m_we, ewe);
                chk("m_be", m_be, ebe);
                if (wd) chk("m_wdata", m_wdata, ewd);
            end
            last = (k == end_k);
            erd  = (last && !ab) ? rd : '0;
            chk("rvalid_own", wd ? d_rvalid : i_rvalid, last);
            chk("err_own",    wd ? d_err : i_err, last && ab);
            chk("rdata_own",  wd ? d_rdata : i_rdata, erd);
            chk("rvalid_other", wd ? i_rvalid : d_rvalid, 0);
            chk("err_other",    wd ? i_err : d_err, 0);
            chk("rdata_other",  wd ? i_rdata : d_rdata, 0);
        end
        n_txn++;
        $display("txn %0d owner=%s addr=%h g=%0d r=%0d %s", n_txn, wd ? "D" : "I", ea, g, r,
                 ab ? "timeout" : "done");
        @(posedge clk);
        #1;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        drive_reqs();
    endtask

    // Idle cycles with no requests and stray memory responses that must be ignored.
    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            i_req = 1'b0; d_req = 1'b0;
            m_gnt = 1'($urandom); m_rvalid = 1'b1; m_rdata = $urandom;
            @(negedge clk);
            chk("idle_busy_low", busy, 0);
            chk("idle_no_mreq", m_req, 0);
            chk("idle_no_gnt", {i_gnt, d_gnt}, 0);
            chk("stray_rvalid", {i_rvalid, d_rvalid, i_err, d_err}, 0);
            @(posedge clk);
            #1;
            m_gnt = 1'b0; m_rvalid = 1'b0;
        end
    endtask

    typedef struct {
        logic          ir, dr;
        logic [AW-1:0] ia;
        logic          dwe;
        logic [BW-1:0] dbe;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd, rd;
        logic          eig, edg, ewe;
        logic [BW-1:0] ebe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ir dr ia dwe dbe da dwd rd | eig edg ewe ebe ea ewd
        vt[0] = '{1'b1, 1'b0, 32'h40, 1'b0, 4'hF, 32'h0,   32'h0,    32'h11111111, 1'b1, 1'b0, 1'b0, 4'hF, 32'h40,  32'h0};
        vt[1] = '{1'b0, 1'b1, 32'h0,  1'b0, 4'hF, 32'h80,  32'h0,    32'h22222222, 1'b0, 1'b1, 1'b0, 4'hF, 32'h80,  32'h0};
        vt[2] = '{1'b1, 1'b1, 32'h44, 1'b1, 4'h3, 32'h100, 32'h1234, 32'h33333333, 1'b1, 1'b0, 1'b0, 4'hF, 32'h44,  32'h0};
        vt[3] = '{1'b1, 1'b1, 32'h44, 1'b1, 4'h3, 32'h100, 32'h1234, 32'h44444444, 1'b0, 1'b1, 1'b1, 4'h3, 32'h100, 32'h1234};
        vt[4] = '{1'b0, 1'b1, 32'h0,  1'b1, 4'hC, 32'h200, 32'hCAFE, 32'h55555555, 1'b0, 1'b1, 1'b1, 4'hC, 32'h200, 32'hCAFE};
        vt[5] = '{1'b1, 1'b1, 32'h48, 1'b0, 4'hF, 32'h300, 32'h0,    32'h66666666, 1'b1, 1'b0, 1'b0, 4'hF, 32'h48,  32'h0};
        vt[6] = '{1'b1, 1'b0, 32'h4C, 1'b0, 4'hF, 32'h0,   32'h0,    32'h77777777, 1'b1, 1'b0, 1'b0, 4'hF, 32'h4C,  32'h0};
        vt[7] = '{1'b1, 1'b1, 32'h50, 1'b1, 4'h1, 32'h400, 32'h55,   32'h88888888, 1'b0, 1'b1, 1'b1, 4'h1, 32'h400, 32'h55};

        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_addr = '0;
        d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        p_ia = '0; p_da = '0; p_dwe = 1'b0; p_dbe = '0; p_dwd = '0;
        #3;
        chk_all_zero("reset");
        do_reset();

        // Arbitration / payload table with zero-wait memory.
        for (int i = 0; i < 8; i++) begin
            i_req = vt[i].ir; i_addr = vt[i].ia;
            d_req = vt[i].dr; d_we = vt[i].dwe; d_be = vt[i].dbe;
            d_addr = vt[i].da; d_wdata = vt[i].dwd;
            m_gnt = 1'b0; m_rvalid = 1'b0;
            @(negedge clk);
            chk("tbl_gnt_i", i_gnt, vt[i].eig);
            chk("tbl_gnt_d", d_gnt, vt[i].edg);
            @(posedge clk);
            #1;
            i_req = 1'b0; d_req = 1'b0;
            m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = vt[i].rd;
            @(negedge clk);
            chk("tbl_mreq", m_req, 1);
            chk("tbl_mwe", m_we, vt[i].ewe);
            chk("tbl_mbe", m_be, vt[i].ebe);
            chk("tbl_maddr", m_addr, vt[i].ea);
            if (vt[i].edg) chk("tbl_mwdata", m_wdata, vt[i].ewd);
            chk("tbl_rvalid_i", i_rvalid, vt[i].eig);
            chk("tbl_rvalid_d", d_rvalid, vt[i].edg);
            chk("tbl_rdata_i", i_rdata, vt[i].eig ? vt[i].rd : 32'h0);
            chk("tbl_rdata_d", d_rdata, vt[i].edg ? vt[i].rd : 32'h0);
            chk("tbl_err", {i_err, d_err}, 0);
            $display("tbl %0d gnt_i=%0b gnt_d=%0b addr=%h", i, vt[i].eig, vt[i].edg, vt[i].ea);
            @(posedge clk);
            #1;
            m_gnt = 1'b0; m_rvalid = 1'b0;
        end

        // Both ports requesting continuously from reset: D, I, D, I.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            if (!p_i) begin p_i = 1'b1; p_ia = 32'h1000 + 32'(n * 4); end
            if (!p_d) begin
                p_d = 1'b1; p_dwe = 1'b1; p_dbe = 4'hF;
                p_da = 32'h2000 + 32'(n * 4); p_dwd = $urandom;
            end
            run_txn(1, 1, $urandom);
            chk("alt_order", obs_gnt_d, (n % 2) == 0);
        end
        run_txn(1, 0, $urandom);

        // Fetch read with delayed grant and response.
        p_i = 1'b1; p_ia = 32'h40;
        run_txn(3, 3, 32'hDEADBEEF);
        idle_check(1);

        // Data write held until memory grant.
        p_d = 1'b1; p_dwe = 1'b1; p_dbe = 4'b0011; p_da = 32'h100; p_dwd = 32'h1234;
        run_txn(3, 2, $urandom);

        // Zero-wait completion followed immediately by the queued request.
        p_i = 1'b1; p_ia = 32'h80;
        run_txn(1, 1, $urandom);
        p_i = 1'b1; p_ia = 32'h84;
        p_d = 1'b1; p_dwe = 1'b0; p_dbe = 4'hF; p_da = 32'h180; p_dwd = '0;
        run_txn(1, 0, 32'hA5A5A5A5);
        run_txn(2, 0, 32'h5A5A5A5A);

        // Timeouts: once in WAIT, once with memory never granting.
        p_d = 1'b1; p_dwe = 1'b0; p_dbe = 4'hF; p_da = 32'h500; p_dwd = '0;
        run_txn(1, 30, $urandom);
        idle_check(3);
        p_i = 1'b1; p_ia = 32'h504;
        run_txn(20, 0, $urandom);
        idle_check(1);

        // Reset asserted while waiting for the response.
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h600; i_req = 1'b0;
        m_gnt = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_gnt", d_gnt, 1);
        @(posedge clk); #1;
        d_req = 1'b0; m_gnt = 1'b1;
        @(negedge clk);
        chk("t6_mreq", m_req, 1);
        @(posedge clk); #1;
        m_gnt = 1'b0;
        @(negedge clk);
        chk("t6_wait_busy", busy, 1);
        chk("t6_wait_mreq", m_req, 0);
        @(posedge clk); #1;
        i_req = 1'b1; d_req = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_rst");
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h600D600D;
        @(negedge clk);
        chk("t6_no_resp", {i_rvalid, d_rvalid}, 0);
        chk("t6_busy", busy, 0);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        m_last_d = 1'b0; p_i = 1'b0; p_d = 1'b0;
        p_d = 1'b1; p_dwe = 1'b1; p_dbe = 4'hF; p_da = 32'h604; p_dwd = 32'h77;
        run_txn(2, 1, $urandom);

        // Random traffic with held losing requests.
        for (int t = 0; t < 60; t++) begin
            if (!p_i && $urandom_range(0, 1) == 1) begin p_i = 1'b1; p_ia = $urandom; end
            if (!p_d && $urandom_range(0, 1) == 1) begin
                p_d = 1'b1; p_dwe = 1'($urandom); p_dbe = 4'($urandom);
                p_da = $urandom; p_dwd = $urandom;
            end
            if (!p_i && !p_d) begin p_i = 1'b1; p_ia = $urandom; end
            run_txn(int'($urandom_range(1, 9)), int'($urandom_range(0, 5)), $urandom);
            if (!p_i && !p_d && $urandom_range(0, 7) == 0) idle_check(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
